systolic_host: RTL and testbench

SYSTOLIC_HOST -- requirements
Module: systolic_host

---
 rtl/systolic_host_pkg.sv | 31 +++
 rtl/systolic_host_ram.sv | 32 +++
 rtl/systolic_host.sv | 180 ++++++++++++++++++
 tb/tb_systolic_host.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_host_pkg.sv
// systolic_pkg -- shared types and sizing helpers for the systolic array host.
//
// Contents:
//   state_e   : one-hot host FSM state encoding
//   ops_f     : operand buffer depth, steps * (columns + rows)
//   macs_f    : result buffer depth, columns * rows
//   addr_w_f  : address width for a buffer of n entries (never below 1 bit)
package systolic_pkg;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    SEND    = 6'b000010,
    WAIT    = 6'b000100,
    FLUSH   = 6'b001000,
    COLLECT = 6'b010000,
    DONE    = 6'b100000
  } state_e;

  function automatic int ops_f(input int cols, input int rows, input int steps);
    return steps * (cols + rows);
  endfunction

  function automatic int macs_f(input int cols, input int rows);
    return cols * rows;
  endfunction

  function automatic int addr_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_host_ram.sv
// systolic_host_ram -- simple buffer with one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
module systolic_host_ram #(
  parameter int width_p  = 32,
  parameter int depth_p  = 4,
  parameter int addr_w_p = 2
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [addr_w_p-1:0] waddr_i,
  input  logic [width_p-1:0]  wdata_i,
  input  logic [addr_w_p-1:0] raddr_i,
  output logic [width_p-1:0]  rdata_o
);

  logic [width_p-1:0] mem_r [depth_p];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_r[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/systolic_host.sv
// systolic_host -- host-side sequencer for a systolic array.
//
// Operands are written into a local buffer while idle, streamed to the array
// on a valid/ready link, the host then waits for the array to go busy and
// idle again, pulses a flush, collects MACS results from a valid/yumi link
// into a result buffer, and pulses done. Results are readable combinationally
// through res_addr_i/res_data_o.
//
// Ports:
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   en_i                    : global enable, low freezes all state
//   op_we_i/op_addr_i/op_data_i : operand buffer write (honoured only in IDLE)
//   start_i                 : start request (honoured only in IDLE)
//   busy_o, done_o          : not-idle status, one-cycle completion pulse
//   valid_o/data_o/ready_i  : operand stream to the array
//   flush_o                 : one-cycle array flush request
//   valid_i/data_i/yumi_o   : result stream from the array
//   array_busy_i            : array compute in progress
//   res_addr_i/res_data_o   : combinational result read
//   error_o                 : sticky WAIT timeout flag (SYSTOLIC_HOST_TIMEOUT_EN only)
//
// Build option: define SYSTOLIC_HOST_TIMEOUT_EN to bound WAIT to wait_max_p
// cycles; on expiry the host flushes anyway and raises error_o until reset.
module systolic_host
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int steps_p        = 1,
  parameter int wait_max_p     = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic op_we_i,
  input  logic [addr_w_f(ops_f(array_width_p, array_height_p, steps_p))-1:0] op_addr_i,
  input  logic [width_p-1:0] op_data_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic valid_o,
  output logic [width_p-1:0] data_o,
  input  logic ready_i,
  output logic flush_o,
  input  logic valid_i,
  input  logic [width_p-1:0] data_i,
  output logic yumi_o,
  input  logic array_busy_i,
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
  output logic error_o,
`endif
  input  logic [addr_w_f(macs_f(array_width_p, array_height_p))-1:0] res_addr_i,
  output logic [width_p-1:0] res_data_o
);

  localparam int OPS    = ops_f(array_width_p, array_height_p, steps_p);
  localparam int MACS   = macs_f(array_width_p, array_height_p);
  localparam int OP_AW  = addr_w_f(OPS);
  localparam int RES_AW = addr_w_f(MACS);

  localparam logic [OP_AW-1:0]  SEND_LAST = OP_AW'(OPS - 1);
  localparam logic [RES_AW-1:0] RES_LAST  = RES_AW'(MACS - 1);

  if (wait_max_p < 1) begin : g_wait_max_chk
    $error("systolic_host: wait_max_p must be at least 1");
  end

  state_e             state_r;
  logic [OP_AW-1:0]   send_cnt_r;
  logic [RES_AW-1:0]  res_cnt_r;
  logic               seen_busy_r;

`ifdef SYSTOLIC_HOST_TIMEOUT_EN
  localparam int WAIT_W = addr_w_f(wait_max_p);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(wait_max_p - 1);
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               error_r;
`endif

  logic op_we;
  logic res_we;

  // Buffer writes obey en_i like every other piece of state.
  assign op_we  = (state_r == IDLE)    && op_we_i && en_i;
  assign res_we = (state_r == COLLECT) && valid_i && en_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      send_cnt_r  <= '0;
      res_cnt_r   <= '0;
      seen_busy_r <= 1'b0;
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
      wait_cnt_r  <= '0;
      error_r     <= 1'b0;
`endif
    end else if (en_i) begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r     <= SEND;
            send_cnt_r  <= '0;
            res_cnt_r   <= '0;
            seen_busy_r <= 1'b0;
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
            wait_cnt_r  <= '0;
`endif
          end
        end
        SEND: begin
          // Counter parks on the last index rather than wrapping.
          if (ready_i) begin
            if (send_cnt_r == SEND_LAST) state_r    <= WAIT;
            else                         send_cnt_r <= send_cnt_r + OP_AW'(1);
          end
        end
        WAIT: begin
          // The array must be seen busy first so a slow start is not
          // mistaken for completion.
          if (array_busy_i)     seen_busy_r <= 1'b1;
          else if (seen_busy_r) state_r     <= FLUSH;
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
          if (wait_cnt_r == WAIT_LAST) begin
            state_r <= FLUSH;
            error_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
`endif
        end
        FLUSH: state_r <= COLLECT;
        COLLECT: begin
          if (valid_i) begin
            if (res_cnt_r == RES_LAST) state_r   <= DONE;
            else                       res_cnt_r <= res_cnt_r + RES_AW'(1);
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state_r != IDLE);
  assign valid_o = (state_r == SEND);
  assign flush_o = (state_r == FLUSH);
  assign done_o  = (state_r == DONE);
  assign yumi_o  = (state_r == COLLECT) && valid_i;
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
  assign error_o = error_r;
`endif

  systolic_host_ram #(
    .width_p  (width_p),
    .depth_p  (OPS),
    .addr_w_p (OP_AW)
  ) u_op_ram (
    .clk_i   (clk_i),
    .we_i    (op_we),
    .waddr_i (op_addr_i),
    .wdata_i (op_data_i),
    .raddr_i (send_cnt_r),
    .rdata_o (data_o)
  );

  systolic_host_ram #(
    .width_p  (width_p),
    .depth_p  (MACS),
    .addr_w_p (RES_AW)
  ) u_res_ram (
    .clk_i   (clk_i),
    .we_i    (res_we),
    .waddr_i (res_cnt_r),
    .wdata_i (data_i),
    .raddr_i (res_addr_i),
    .rdata_o (res_data_o)
  );

endmodule

// File: tb/tb_systolic_host.sv
module tb_systolic_host;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, en, op_we, start, busy, done, vld_out, ready, flush;
  logic vld_in, yumi, abusy;
  logic [1:0] op_addr, res_addr;
  logic [W-1:0] op_data, data_out, data_in, res_data;
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
  logic error;
`endif

  int n_chk = 0;
  int n_pass = 0;

  systolic_host #(
    .width_p(W), .array_width_p(2), .array_height_p(2), .steps_p(1), .wait_max_p(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
    .op_we_i(op_we), .op_addr_i(op_addr), .op_data_i(op_data),
    .start_i(start), .busy_o(busy), .done_o(done),
    .valid_o(vld_out), .data_o(data_out), .ready_i(ready),
    .flush_o(flush),
    .valid_i(vld_in), .data_i(data_in), .yumi_o(yumi),
    .array_busy_i(abusy),
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
    .error_o(error),
`endif
    .res_addr_i(res_addr), .res_data_o(res_data)
  );

  typedef struct {
    logic start, ready, abusy, vin;
    logic [W-1:0] din;
    logic we;
    logic [W-1:0] wdata;
    logic e_busy, e_valid;
    logic [W-1:0] e_data;
    logic e_flush, e_yumi, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, r, ab, vi, input logic [W-1:0] di,
                              input logic we, input logic [W-1:0] wd,
                              input logic eb, ev, input logic [W-1:0] ed,
                              input logic ef, ey, edn);
    vec_t v;
    v.start = s;  v.ready = r;   v.abusy = ab;  v.vin = vi;  v.din = di;
    v.we = we;    v.wdata = wd;  v.e_busy = eb; v.e_valid = ev;
    v.e_data = ed; v.e_flush = ef; v.e_yumi = ey; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      start = tbl[i].start; ready = tbl[i].ready; abusy = tbl[i].abusy;
      vld_in = tbl[i].vin;  data_in = tbl[i].din;
      op_we = tbl[i].we;    op_addr = 2'd0;       op_data = tbl[i].wdata;
      #1;
      chk($sformatf("vec%0d busy", i),  W'(busy),    W'(tbl[i].e_busy));
      chk($sformatf("vec%0d valid", i), W'(vld_out), W'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("vec%0d data", i), data_out, tbl[i].e_data);
      chk($sformatf("vec%0d flush", i), W'(flush),   W'(tbl[i].e_flush));
      chk($sformatf("vec%0d yumi", i),  W'(yumi),    W'(tbl[i].e_yumi));
      chk($sformatf("vec%0d done", i),  W'(done),    W'(tbl[i].e_done));
    end
  endtask

  task automatic check_res(input int a, input logic [W-1:0] exp);
    @(negedge clk);
    res_addr = 2'(a);
    #1;
    chk($sformatf("res[%0d]", a), res_data, exp);
  endtask

  int a_end;

  initial begin
    // Table A: full-speed send, busy for 5 cycles, results 10..40.
    tbl.push_back(mk(1,1,0,0,0,  0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0, 1,1,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0, 1,1,2,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0, 1,1,3,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0, 1,1,4,0,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,1,1,0,0, 0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,  0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,77, 0,0, 1,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,1,10, 0,0, 1,0,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,20, 0,0, 1,0,0,0,1,0));
    tbl.push_back(mk(0,1,0,1,30, 0,0, 1,0,0,0,1,0));
    tbl.push_back(mk(0,1,0,1,40, 0,0, 1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0, 1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,  0,0, 0,0,0,0,0,0));
    a_end = tbl.size();
    // Table B: ready toggling, start during SEND, operand writes during COLLECT.
    tbl.push_back(mk(1,0,0,0,0,  0,0,  0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,  1,1,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0,  1,1,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,  0,0,  1,1,2,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0,  1,1,2,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,  1,1,3,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0,  1,1,3,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,  1,1,4,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0,  1,1,4,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,  1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,  0,0,  1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,  1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,  1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,5,  1,99, 1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,6,  1,99, 1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,7,  0,0,  1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,8,  0,0,  1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,  0,0,  1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,  0,0,  0,0,0,0,0,0));

    // Reset state, with valid_i high to show yumi_o stays low.
    reset_n = 1'b0; en = 1'b1; op_we = 1'b0; op_addr = '0; op_data = '0;
    start = 1'b0; ready = 1'b0; vld_in = 1'b1; data_in = '0; abusy = 1'b0;
    res_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", W'(busy), 0);
    chk("rst valid", W'(vld_out), 0);
    chk("rst flush", W'(flush), 0);
    chk("rst yumi", W'(yumi), 0);
    chk("rst done", W'(done), 0);
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
    chk("rst error", W'(error), 0);
`endif
    reset_n = 1'b1; vld_in = 1'b0;

    // Operand load 1,2,3,4.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op_we = 1'b1; op_addr = 2'(i); op_data = W'(i + 1);
    end
    @(negedge clk);
    op_we = 1'b0;

    run_range(0, a_end);
    for (int i = 0; i < 4; i++) check_res(i, W'(10 * (i + 1)));

    run_range(a_end, tbl.size());
    for (int i = 0; i < 4; i++) check_res(i, W'(5 + i));

    // Reset in COLLECT after two results; operands must be unchanged.
    @(negedge clk);
    start = 1'b1; ready = 1'b1; abusy = 1'b0; vld_in = 1'b0; op_we = 1'b0;
    #1 chk("C idle busy", W'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk($sformatf("C send%0d valid", k), W'(vld_out), 1);
      chk($sformatf("C send%0d data", k), data_out, W'(k + 1));
    end
    @(negedge clk); abusy = 1'b1;
    #1 chk("C wait valid", W'(vld_out), 0);
    @(negedge clk); abusy = 1'b0;
    #1 chk("C wait flush", W'(flush), 0);
    @(negedge clk);
    #1 chk("C flush", W'(flush), 1);
    @(negedge clk); vld_in = 1'b1; data_in = 111;
    #1 chk("C yumi0", W'(yumi), 1);
    @(negedge clk); data_in = 222;
    #1 chk("C yumi1", W'(yumi), 1);
    @(negedge clk); data_in = 333;
    #1 reset_n = 1'b0;
    #1;
    chk("C rst busy", W'(busy), 0);
    chk("C rst valid", W'(vld_out), 0);
    chk("C rst flush", W'(flush), 0);
    chk("C rst yumi", W'(yumi), 0);
    chk("C rst done", W'(done), 0);
    @(negedge clk);
    reset_n = 1'b1; vld_in = 1'b0; ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("C post done%0d", k), W'(done), 0);
      chk($sformatf("C post busy%0d", k), W'(busy), 0);
    end
    check_res(0, 111);
    check_res(1, 222);
    check_res(2, 7);
    check_res(3, 8);

`ifdef SYSTOLIC_HOST_TIMEOUT_EN
    // array_busy_i stuck low: timeout flush after 8 WAIT cycles.
    @(negedge clk);
    start = 1'b1; ready = 1'b1; abusy = 1'b0; vld_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1 chk($sformatf("T send%0d data", k), data_out, W'(k + 1));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("T wait%0d flush", k), W'(flush), 0);
      chk($sformatf("T wait%0d error", k), W'(error), 0);
    end
    @(negedge clk);
    #1;
    chk("T flush", W'(flush), 1);
    chk("T error", W'(error), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vld_in = 1'b1; data_in = W'(k);
    end
    @(negedge clk);
    vld_in = 1'b0;
    #1;
    chk("T done", W'(done), 1);
    chk("T error sticky", W'(error), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
